// File: rtl/vc_test_sink_pkg.sv
// Shared definitions for the random-delay test sink: FSM states, LFSR constants
// and the encoding used by first_fail when no mismatch has been seen.
package vc_test_sink_pkg;

    typedef enum logic [1:0] {
        DELAY = 2'd0,
        READY = 2'd1,
        DONE  = 2'd2
    } sink_state_e;

    localparam int unsigned         LFSR_W          = 16;
    localparam logic [LFSR_W-1:0]   LFSR_POLY       = 16'hB400;
    localparam logic [31:0]         FIRST_FAIL_NONE = 32'hFFFF_FFFF;

    // One Galois step: shift right, fold the polynomial back in when a 1 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
        logic [LFSR_W-1:0] shifted;
        shifted = {1'b0, x[LFSR_W-1:1]};
        return x[0] ? (shifted ^ LFSR_POLY) : shifted;
    endfunction

    // An all-zero state would lock the LFSR, so it is never used as a seed.
    function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
    endfunction

endpackage

// File: rtl/vc_test_rand_delay_sink_if.sv
// val/rdy message stream between a producer (master) and the test sink (slave).
interface vc_test_rand_delay_sink_if #(
    parameter int unsigned p_msg_sz = 1
);
    logic                val;
    logic                rdy;
    logic [p_msg_sz-1:0] msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/vc_test_lfsr16.sv
// 16-bit Galois LFSR that advances once per cycle with en high; shared by the
// random-delay source and sink so both draw from the same sequence.
module vc_test_lfsr16
    import vc_test_sink_pkg::*;
#(
    parameter logic [LFSR_W-1:0] seed = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [LFSR_W-1:0] out,
    output logic [LFSR_W-1:0] out_next
);

    localparam logic [LFSR_W-1:0] c_seed = lfsr_seed_fix(seed);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        out_next = lfsr_step(lfsr_q);
        lfsr_d   = en ? out_next : lfsr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= c_seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/vc_test_rand_delay_sink.sv
// Test-harness sink: throttles rdy with LFSR-driven back-pressure, checks each
// accepted message in order against a preloaded table and counts mismatches.
module vc_test_rand_delay_sink
    import vc_test_sink_pkg::*;
#(
    parameter int unsigned p_msg_sz    = 1,
    parameter int unsigned p_mem_sz    = 1024,
    parameter int unsigned p_max_delay = 0,
    parameter logic [15:0] p_seed      = 16'hACE1,
    localparam int unsigned c_aw = $clog2(p_mem_sz),
    localparam int unsigned c_nw = c_aw + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    vc_test_rand_delay_sink_if.slave s,
    input  logic                  cfg_we,
    input  logic [c_aw-1:0]       cfg_addr,
    input  logic [p_msg_sz-1:0]   cfg_data,
    input  logic [c_nw-1:0]       cfg_num,
    output logic                  done,
    output logic [15:0]           num_failed,
    output logic [c_nw-1:0]       first_fail
);

    localparam int unsigned       c_mod     = p_max_delay + 1;
    localparam int unsigned       c_dw      = (p_max_delay > 0) ? $clog2(p_max_delay + 1) : 1;
    localparam logic [c_dw-1:0]   c_cnt_rst = c_dw'(32'(p_seed) % c_mod);
    localparam logic [c_nw-1:0]   c_ff_none = FIRST_FAIL_NONE[c_nw-1:0];
    localparam logic [c_nw-1:0]   c_mem_sz  = c_nw'(p_mem_sz);

    logic [p_msg_sz-1:0] mem_q [p_mem_sz];

    sink_state_e       state_q, state_d;
    logic [c_dw-1:0]   cnt_q, cnt_d;
    logic [c_nw-1:0]   idx_q, idx_d;
    logic [15:0]       num_failed_q, num_failed_d;
    logic [c_nw-1:0]   first_fail_q, first_fail_d;

    logic [c_nw-1:0]     cfg_num_eff;
    logic [c_nw-1:0]     idx_inc;
    logic [p_msg_sz-1:0] exp_msg;
    logic                xfer;
    logic                mismatch;
    logic [c_dw-1:0]     draw;
    logic [15:0]         lfsr_next;
    logic [15:0]         lfsr_cur_unused;

    vc_test_lfsr16 #(
        .seed (p_seed)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .en       (xfer),
        .out      (lfsr_cur_unused),
        .out_next (lfsr_next)
    );

    // The table has no reset; a write lands on the edge, so a read of the same
    // index in that cycle still sees the previous contents.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            mem_q[cfg_addr] <= cfg_data;
        end
    end

    assign cfg_num_eff = (cfg_num > c_mem_sz) ? c_mem_sz : cfg_num;
    assign idx_inc     = idx_q + c_nw'(1);
    assign exp_msg     = mem_q[idx_q[c_aw-1:0]];
    assign xfer        = (state_q == READY) && s.val;
    assign mismatch    = xfer && (s.msg != exp_msg);
    assign draw        = c_dw'(32'(lfsr_next) % c_mod);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        num_failed_d = num_failed_q;
        first_fail_d = first_fail_q;

        if (xfer) begin
            idx_d = idx_inc;
        end
        if (mismatch) begin
            if (num_failed_q != 16'hFFFF) begin
                num_failed_d = num_failed_q + 16'd1;
            end
            if (first_fail_q == c_ff_none) begin
                first_fail_d = idx_q;
            end
        end

        case (state_q)
            DELAY: begin
                if (cnt_q == '0) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q - c_dw'(1);
                end
            end
            READY: begin
                if (xfer) begin
                    if (idx_inc == cfg_num_eff) begin
                        state_d = DONE;
                    end else if (draw != '0) begin
                        state_d = DELAY;
                        cnt_d   = draw - c_dw'(1);
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = DONE;
        endcase

        // Exhausted (or empty) table wins over everything, including cfg_num == 0.
        if (idx_q >= cfg_num_eff) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= DELAY;
            cnt_q        <= c_cnt_rst;
            idx_q        <= '0;
            num_failed_q <= '0;
            first_fail_q <= c_ff_none;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            num_failed_q <= num_failed_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign s.rdy      = (state_q == READY);
    assign done       = (state_q == DONE);
    assign num_failed = num_failed_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_vc_test_rand_delay_sink.sv
// Directed bench for vc_test_rand_delay_sink: three instances cover pass-through and
// corner cases, LFSR-driven back-pressure, and saturation of the mismatch counter.
module tb_vc_test_rand_delay_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Instance A: no back-pressure, 32-entry table
    logic        reset_a;
    logic        cfg_we_a;
    logic [4:0]  cfg_addr_a;
    logic [7:0]  cfg_data_a;
    logic [5:0]  cfg_num_a;
    logic        done_a;
    logic [15:0] nf_a;
    logic [5:0]  ff_a;
    vc_test_rand_delay_sink_if #(.p_msg_sz(8)) if_a ();
    vc_test_rand_delay_sink #(.p_msg_sz(8), .p_mem_sz(32), .p_max_delay(0), .p_seed(16'hACE1)) dut_a (
        .clk(clk), .reset(reset_a), .s(if_a), .cfg_we(cfg_we_a), .cfg_addr(cfg_addr_a),
        .cfg_data(cfg_data_a), .cfg_num(cfg_num_a), .done(done_a), .num_failed(nf_a), .first_fail(ff_a));

    // Instance B: random back-pressure up to 3 cycles
    logic        reset_b;
    logic        cfg_we_b;
    logic [4:0]  cfg_addr_b;
    logic [7:0]  cfg_data_b;
    logic [5:0]  cfg_num_b;
    logic        done_b;
    logic [15:0] nf_b;
    logic [5:0]  ff_b;
    vc_test_rand_delay_sink_if #(.p_msg_sz(8)) if_b ();
    vc_test_rand_delay_sink #(.p_msg_sz(8), .p_mem_sz(32), .p_max_delay(3), .p_seed(16'hACE1)) dut_b (
        .clk(clk), .reset(reset_b), .s(if_b), .cfg_we(cfg_we_b), .cfg_addr(cfg_addr_b),
        .cfg_data(cfg_data_b), .cfg_num(cfg_num_b), .done(done_b), .num_failed(nf_b), .first_fail(ff_b));

    // Instance C: 64K table for counter saturation
    logic        reset_c;
    logic        cfg_we_c;
    logic [15:0] cfg_addr_c;
    logic [0:0]  cfg_data_c;
    logic [16:0] cfg_num_c;
    logic        done_c;
    logic [15:0] nf_c;
    logic [16:0] ff_c;
    vc_test_rand_delay_sink_if #(.p_msg_sz(1)) if_c ();
    vc_test_rand_delay_sink #(.p_msg_sz(1), .p_mem_sz(65536), .p_max_delay(0), .p_seed(16'hACE1)) dut_c (
        .clk(clk), .reset(reset_c), .s(if_c), .cfg_we(cfg_we_c), .cfg_addr(cfg_addr_c),
        .cfg_data(cfg_data_c), .cfg_num(cfg_num_c), .done(done_c), .num_failed(nf_c), .first_fail(ff_c));

    // Reference state for instance A
    logic [7:0]  tbl_a [32];
    int          m_idx;
    logic [15:0] m_nf;
    logic [5:0]  m_ff;
    logic [31:0] exp_res_q [$];
    logic [31:0] exp_gap_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] x);
        ref_step = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic write_a(input logic [4:0] a, input logic [7:0] d);
        cfg_we_a = 1'b1; cfg_addr_a = a; cfg_data_a = d;
        tick();
        cfg_we_a = 1'b0;
        tbl_a[a] = d;
    endtask

    task automatic restart_a(input logic [5:0] num);
        reset_a = 1'b1; if_a.val = 1'b0; cfg_num_a = num;
        tick();
        reset_a = 1'b0;
        m_idx = 0; m_nf = '0; m_ff = '1;
        exp_res_q.delete();
        tick();
    endtask

    // Drive one message, wait (bounded) for rdy, let it transfer and score the result.
    task automatic send_a(input logic [7:0] m, output int waited);
        waited = 0;
        if_a.val = 1'b1; if_a.msg = m;
        while (!if_a.rdy && waited < 20) begin
            tick();
            waited++;
        end
        if (m_idx < 32 && m !== tbl_a[m_idx]) begin
            if (m_nf != 16'hFFFF) m_nf = m_nf + 16'd1;
            if (m_ff == 6'h3F) m_ff = 6'(m_idx);
        end
        m_idx++;
        exp_res_q.push_back({10'b0, m_ff, m_nf});
        tick();
        if_a.val = 1'b0; if_a.msg = 'x;
        check("a_result", {10'b0, ff_a, nf_a}, exp_res_q.pop_front());
    endtask

    initial begin
        int w;
        int stall;
        int g;
        int cnt;
        logic [15:0] lf;

        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        if_a.val = 1'b0; if_b.val = 1'b0; if_c.val = 1'b0;
        if_a.msg = '0; if_b.msg = '0; if_c.msg = '0;
        cfg_we_a = 1'b0; cfg_addr_a = '0; cfg_data_a = '0; cfg_num_a = '0;
        cfg_we_b = 1'b0; cfg_addr_b = '0; cfg_data_b = '0; cfg_num_b = 6'd20;
        cfg_we_c = 1'b0; cfg_addr_c = '0; cfg_data_c = '0; cfg_num_c = 17'd65536;
        m_idx = 0; m_nf = '0; m_ff = '1;

        // Table loads while all instances are held in reset
        for (int i = 0; i < 32; i++) begin
            cfg_we_b = 1'b1; cfg_addr_b = 5'(i); cfg_data_b = 8'(8'h40 + i);
            cfg_we_c = (i == 0); cfg_addr_c = '0; cfg_data_c = 1'b0;
            write_a(5'(i), 8'(i + 1));
        end
        cfg_we_b = 1'b0; cfg_we_c = 1'b0;

        check("rst_rdy", 32'(if_a.rdy), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_num_failed", 32'(nf_a), 32'd0);
        check("rst_first_fail", 32'(ff_a), 32'h3F);

        // Pass-through, with a same-cycle write to the index being checked
        restart_a(6'd3);
        check("pt_first_rdy", 32'(if_a.rdy), 32'd1);
        cfg_we_a = 1'b1; cfg_addr_a = 5'd0; cfg_data_a = 8'hAA;
        send_a(8'h01, w);
        cfg_we_a = 1'b0; tbl_a[0] = 8'hAA;
        stall = w;
        send_a(8'h02, w); stall += w;
        check("pt_done_early", 32'(done_a), 32'd0);
        send_a(8'h03, w); stall += w;
        check("pt_consecutive", 32'(stall), 32'd0);
        check("pt_done", 32'(done_a), 32'd1);
        check("pt_rdy_low", 32'(if_a.rdy), 32'd0);
        check("pt_num_failed", 32'(nf_a), 32'd0);
        check("pt_first_fail", 32'(ff_a), 32'h3F);
        write_a(5'd0, 8'h01);
        if_a.val = 1'b1; if_a.msg = 8'hFF;
        tick(); tick();
        if_a.val = 1'b0;
        check("done_ignores_val", 32'(nf_a), 32'd0);
        check("done_sticky", 32'(done_a), 32'd1);

        // Mismatch on the second message
        restart_a(6'd3);
        send_a(8'h01, w);
        send_a(8'hFF, w);
        send_a(8'h03, w);
        check("mm_num_failed", 32'(nf_a), 32'd1);
        check("mm_first_fail", 32'(ff_a), 32'd1);
        check("mm_done", 32'(done_a), 32'd1);

        // Empty table
        restart_a(6'd0);
        check("empty_done", 32'(done_a), 32'd1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (if_a.rdy) cnt++;
            tick();
        end
        check("empty_never_rdy", 32'(cnt), 32'd0);

        // Stall in READY with val low
        restart_a(6'd3);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if_a.rdy) cnt++;
        end
        check("stall_rdy_held", 32'(cnt), 32'd10);
        check("stall_not_done", 32'(done_a), 32'd0);
        send_a(8'h01, w);
        send_a(8'h02, w);
        check("stall_done_early", 32'(done_a), 32'd0);
        send_a(8'h03, w);
        check("stall_done", 32'(done_a), 32'd1);
        check("stall_num_failed", 32'(nf_a), 32'd0);

        // cfg_num above the table depth clamps to 32
        restart_a(6'd40);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) check("clamp_done_early", 32'(done_a), 32'd0);
            send_a(8'(i + 1), w);
        end
        check("clamp_done", 32'(done_a), 32'd1);

        // Reset mid-stream, asserted between clock edges
        restart_a(6'd5);
        send_a(8'h01, w);
        send_a(8'h77, w);
        check("mid_pre_failed", 32'(nf_a), 32'd1);
        #2;
        reset_a = 1'b1;
        #1;
        check("mid_rst_rdy", 32'(if_a.rdy), 32'd0);
        check("mid_rst_done", 32'(done_a), 32'd0);
        check("mid_rst_num_failed", 32'(nf_a), 32'd0);
        check("mid_rst_first_fail", 32'(ff_a), 32'h3F);
        tick();
        reset_a = 1'b0;
        m_idx = 0; m_nf = '0; m_ff = '1;
        tick();
        for (int i = 0; i < 5; i++) send_a(8'(i + 1), w);
        check("mid_replay_done", 32'(done_a), 32'd1);
        check("mid_replay_failed", 32'(nf_a), 32'd0);

        // Random back-pressure against a reference LFSR
        reset_b = 1'b0;
        g = 0;
        while (!if_b.rdy && g < 10) begin
            tick();
            g++;
        end
        check("b_first_rdy", 32'(g), 32'(int'(16'hACE1) % 4 + 1));
        lf = 16'hACE1;
        if_b.val = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if_b.msg = 8'(8'h40 + i);
            tick();
            if (i < 19) begin
                lf = ref_step(lf);
                exp_gap_q.push_back(32'(int'(lf) % 4));
                if_b.msg = 8'(8'h40 + i + 1);
                g = 0;
                while (!if_b.rdy && g < 10) begin
                    tick();
                    g++;
                end
                check("b_gap", 32'(g), exp_gap_q.pop_front());
            end
        end
        if_b.val = 1'b0;
        check("b_done", 32'(done_b), 32'd1);
        check("b_num_failed", 32'(nf_b), 32'd0);
        check("b_first_fail", 32'(ff_b), 32'h3F);

        // Saturation: every message mismatches; the next entry is zeroed just ahead of use
        reset_c = 1'b0;
        tick();
        check("c_first_rdy", 32'(if_c.rdy), 32'd1);
        if_c.val = 1'b1; if_c.msg = 1'b1;
        cfg_we_c = 1'b1; cfg_data_c = 1'b0;
        for (int k = 0; k < 65536; k++) begin
            cfg_addr_c = 16'(k + 1);
            tick();
            if (k == 65533) check("c_pre_sat", 32'(nf_c), 32'hFFFE);
        end
        if_c.val = 1'b0; cfg_we_c = 1'b0;
        check("c_saturated", 32'(nf_c), 32'hFFFF);
        check("c_done", 32'(done_c), 32'd1);
        check("c_first_fail", 32'(ff_c), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
